serial_tx_scheduler: RTL
========================

// Module: serial_tx_scheduler
// PURPOSE
//   Shares the single RS232 transmitter between two byte sources: the RISC0 CPU (I/O write
//   to the TX data port) and an auxiliary hardware source (monitor/debug streamer). Buffers
//   each source in its own FIFO so the CPU need not poll transmitter ready per byte. Grants
//   the transmitter round-robin and sequences its start/rdy handshake. Sits in the top level
//   between the I/O decode and the RS232 transmitter.
// PARAMETERS
//   CPU_AW  4  log2 of CPU FIFO depth (16 bytes)
//   AUX_AW  2  log2 of aux FIFO depth (4 bytes)
// PORTS
//   clk        in   1       system clock
//   rst        in   1       asynchronous reset, active-high
//   cpu_wr     in   1       one-cycle CPU write strobe (iowr & TX address match)
//   cpu_data   in   8       CPU byte, sampled when cpu_wr=1
//   cpu_clr    in   1       clears the sticky overflow flag
//   cpu_full   out  1       CPU FIFO full (for the status word on inbus)
//   cpu_empty  out  1       CPU FIFO empty
//   cpu_ovf    out  1       sticky: a CPU write was dropped
//   aux_valid  in   1       aux byte offered
//   aux_data   in   8       aux byte
//   aux_ready  out  1       aux byte accepted when aux_valid & aux_ready
//   tx_start   out  1       one-cycle start pulse to transmitter
//   tx_data    out  8       byte to transmitter, stable from tx_start until tx_rdy returns high
//   tx_rdy     in   1       transmitter idle
//   busy       out  1       FSM not IDLE or any FIFO non-empty
// BEHAVIOUR
//   Reset (async, rst=1): both FIFOs empty, FSM=IDLE, last_grant=AUX, outputs tx_start=0,
//     tx_data=0, cpu_ovf=0, cpu_full=0, cpu_empty=1, aux_ready=1, busy=0. A byte already
//     in the transmitter completes on its own; the scheduler does not wait for it.
//   FIFO push: on cpu_wr, byte stored if not full, or if full and popped in the same cycle.
//     Otherwise dropped and cpu_ovf set; cpu_ovf cleared by cpu_clr (clear wins if both).
//     aux_ready = ~aux_full | aux_pop; aux handshake never drops.
//   Counts are AW+1 bits; pointers AW bits and wrap modulo depth.
//   FSM (registered outputs):
//     IDLE : if tx_rdy & (cpu_nonempty | aux_nonempty): pick source, pop its head into
//            tx_data, tx_start<=1, go SEND. Both non-empty: grant source != last_grant.
//            One non-empty: grant it. Update last_grant on every grant.
//     SEND : tx_start=1 for exactly this cycle; go HOLD.
//     HOLD : tx_start=0; tx_rdy ignored this cycle (transmitter drops rdy); go WAIT.
//     WAIT : stay until tx_rdy=1, then go IDLE.
//   Latency: cpu_wr at edge N into empty system with tx_rdy=1 -> FIFO non-empty in cycle N+1,
//     tx_start high in cycle N+2. Back-to-back bytes: next tx_start 2 cycles after tx_rdy rises.
//   Pop happens only in IDLE on grant; a same-cycle push to the granted empty FIFO is not
//     visible until the next cycle.
//   tx_rdy=0 in IDLE: no grant, FIFOs keep filling.
//   Illegal state encodings return to IDLE.
// STRUCTURE
//   Shared include risc0_io_defs.vh: FSM state codes (IDLE/SEND/HOLD/WAIT), source ids
//     SRC_CPU=0/SRC_AUX=1, I/O word addresses of TX data and status ports.
//   One sub-module: byte_fifo #(AW) (push, pop, din, dout, full, empty, count); instantiated
//     twice. Scheduler body holds arbiter, FSM, overflow flag.
// TESTING
//   1 Reset, tx_rdy=1, cpu_wr 0x41 once -> tx_start pulse 2 cycles later, tx_data=0x41; busy
//     until tx_rdy rises again.
//   2 Fill CPU FIFO with 17 writes while tx_rdy=0 -> 16 stored, cpu_full=1, cpu_ovf=1;
//     cpu_clr -> cpu_ovf=0; release tx_rdy -> 16 bytes sent in order 0x00..0x0F.
//   3 CPU holds 0x10,0x11, aux holds 0xA0,0xA1, start idle -> sent order 0x10,0xA0,0x11,0xA1.
//   4 Aux streams 8 bytes with aux_valid held high, tx_rdy model busy 20 cycles per byte ->
//     aux_ready drops at 4 queued; all 8 sent, none lost or duplicated.
//   5 Assert rst during WAIT with 3 bytes queued -> tx_start=0, FIFOs empty, busy=0 at once;
//     after release no further tx_start.
//   6 CPU FIFO full, cpu_wr in same cycle as grant pop -> byte accepted, cpu_ovf stays 0.

Source files
------------

// File: rtl/serial_tx_scheduler_pkg.sv
// Shared types for the RS232 transmit scheduler: FSM states, source ids,
// I/O word addresses of the TX ports and the round-robin pick function.
package serial_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_WAIT = 2'd3
  } tx_state_t;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_AUX = 1'b1
  } src_t;

  // I/O word addresses decoded outside this block (TX data / TX status)
  localparam logic [3:0] IO_TX_DATA_ADDR = 4'd8;
  localparam logic [3:0] IO_TX_STAT_ADDR = 4'd9;

  function automatic src_t rr_pick(input logic cpu_ne, input logic aux_ne, input src_t last);
    src_t pick;
    if (cpu_ne && aux_ne) begin
      pick = (last == SRC_AUX) ? SRC_CPU : SRC_AUX;
    end else if (cpu_ne) begin
      pick = SRC_CPU;
    end else begin
      pick = SRC_AUX;
    end
    return pick;
  endfunction

endpackage

// File: rtl/serial_tx_scheduler_byte_fifo.sv
// Byte FIFO with 2**AW entries; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one RS232 transmitter between a CPU byte FIFO and an aux byte FIFO,
// granting round-robin and sequencing the transmitter start/rdy handshake.
module serial_tx_scheduler
  import serial_tx_scheduler_pkg::*;
#(
  parameter int CPU_AW = 4,
  parameter int AUX_AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_data,
  input  logic       cpu_clr,
  output logic       cpu_full,
  output logic       cpu_empty,
  output logic       cpu_ovf,
  input  logic       aux_valid,
  input  logic [7:0] aux_data,
  output logic       aux_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_rdy,
  output logic       busy
);

  tx_state_t       state_r;
  tx_state_t       next_state_s;
  src_t            last_grant_r;
  src_t            grant_src_s;
  logic            grant_valid_s;
  logic            cpu_pop_s;
  logic            aux_pop_s;
  logic [7:0]      cpu_dout_s;
  logic [7:0]      aux_dout_s;
  logic            cpu_full_s;
  logic            cpu_empty_s;
  logic            aux_full_s;
  logic            aux_empty_s;
  logic [CPU_AW:0] cpu_count_s;
  logic [AUX_AW:0] aux_count_s;
  logic            tx_start_r;
  logic [7:0]      tx_data_r;
  logic            cpu_ovf_r;

  byte_fifo #(.AW(CPU_AW)) u_cpu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_wr),
    .pop   (cpu_pop_s),
    .din   (cpu_data),
    .dout  (cpu_dout_s),
    .full  (cpu_full_s),
    .empty (cpu_empty_s),
    .count (cpu_count_s)
  );

  byte_fifo #(.AW(AUX_AW)) u_aux_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (aux_valid),
    .pop   (aux_pop_s),
    .din   (aux_data),
    .dout  (aux_dout_s),
    .full  (aux_full_s),
    .empty (aux_empty_s),
    .count (aux_count_s)
  );

  assign cpu_full  = cpu_full_s;
  assign cpu_empty = cpu_empty_s;
  assign cpu_ovf   = cpu_ovf_r;
  assign aux_ready = ~aux_full_s | aux_pop_s;
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign busy      = (state_r != ST_IDLE) | (cpu_count_s != '0) | (aux_count_s != '0);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; HOLD deliberately ignores tx_rdy while it falls.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: next_state_s = grant_valid_s ? ST_SEND : ST_IDLE;
      ST_SEND: next_state_s = ST_HOLD;
      ST_HOLD: next_state_s = ST_WAIT;
      ST_WAIT: next_state_s = tx_rdy ? ST_IDLE : ST_WAIT;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Grant and pop decode; a pop only ever happens from IDLE.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = last_grant_r;
    cpu_pop_s     = 1'b0;
    aux_pop_s     = 1'b0;
    if ((state_r == ST_IDLE) && tx_rdy && (!cpu_empty_s || !aux_empty_s)) begin
      grant_valid_s = 1'b1;
      grant_src_s   = rr_pick(!cpu_empty_s, !aux_empty_s, last_grant_r);
      cpu_pop_s     = (grant_src_s == SRC_CPU);
      aux_pop_s     = (grant_src_s == SRC_AUX);
    end else begin
      grant_valid_s = 1'b0;
    end
  end

  // Registered transmitter outputs and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      last_grant_r <= SRC_AUX;
    end else begin
      tx_start_r <= grant_valid_s;
      if (grant_valid_s) begin
        tx_data_r    <= (grant_src_s == SRC_CPU) ? cpu_dout_s : aux_dout_s;
        last_grant_r <= grant_src_s;
      end
    end
  end

  // Sticky overflow on a dropped CPU write; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ovf_r <= 1'b0;
    end else if (cpu_clr) begin
      cpu_ovf_r <= 1'b0;
    end else if (cpu_wr && cpu_full_s && !cpu_pop_s) begin
      cpu_ovf_r <= 1'b1;
    end
  end

endmodule
